// File: rtl/gps_route_acc_if.sv
// Bus between the distance stage, the route accumulator and its result consumer.
// fsm_state mirrors the accumulator's ACCUM/HOLD state for observation.
interface gps_route_acc_if;
    logic        D_VALID;
    logic [39:0] D_IN;
    logic        OUT_READY;
    logic        OUT_VALID;
    logic [47:0] TOTAL;
    logic [7:0]  SEG_CNT;
    logic [39:0] MAX_SEG;
    logic        OVF;
    logic [0:0]  fsm_state;

    // Result handshake: a route result transfers on a cycle where OUT_VALID and
    // OUT_READY are both 1; once raised, OUT_VALID and the result hold until then.
    modport master (
        output D_VALID, D_IN, OUT_READY,
        input  OUT_VALID, TOTAL, SEG_CNT, MAX_SEG, OVF, fsm_state
    );

    modport slave (
        input  D_VALID, D_IN, OUT_READY,
        output OUT_VALID, TOTAL, SEG_CNT, MAX_SEG, OVF, fsm_state
    );
endinterface

// File: rtl/gps_route_acc.sv
// Buffers segment distances in a small FIFO and sums ROUTE_LEN of them into one route result.
// Define GPS_ROUTE_MAX_EN to track the largest segment on MAX_SEG; otherwise MAX_SEG is 0.
module gps_route_acc #(
    parameter int ROUTE_LEN  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    gps_route_acc_if.slave bus
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [8:0]      LAST_CNT = 9'(ROUTE_LEN);

    logic [39:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [0:0]  state;
    logic        out_valid;
    logic [47:0] total;
    logic [7:0]  seg_cnt;
    logic        ovf;

    logic        full;
    logic        empty;
    logic        wr_en;
    logic        pop;
    logic        hs;
    logic [39:0] pop_data;
    logic [8:0]  seg_next;
    logic        last_seg;

    // Full is judged on the count at cycle start, so a same-cycle pop never rescues a write.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign wr_en    = bus.D_VALID && !full;
    assign pop      = (state == ACCUM) && !empty;
    assign hs       = (state == HOLD) && bus.OUT_READY;
    assign pop_data = mem[rd_ptr];
    assign seg_next = {1'b0, seg_cnt} + 9'd1;
    assign last_seg = (seg_next == LAST_CNT);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.D_IN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            total     <= '0;
            seg_cnt   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (bus.D_VALID && full) begin
                ovf <= 1'b1;
            end
            case (state)
                ACCUM: begin
                    if (pop) begin
                        total   <= total + {8'd0, pop_data};
                        seg_cnt <= seg_next[7:0];
                        if (last_seg) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hs) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        total     <= '0;
                        seg_cnt   <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef GPS_ROUTE_MAX_EN
    logic [39:0] max_q;

    // Pops happen only in ACCUM and the clear only in HOLD, so the two never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q <= '0;
        end else if (pop && (pop_data > max_q)) begin
            max_q <= pop_data;
        end else if (hs) begin
            max_q <= '0;
        end
    end

    assign bus.MAX_SEG = max_q;
`else
    assign bus.MAX_SEG = '0;
`endif

    assign bus.OUT_VALID = out_valid;
    assign bus.TOTAL     = total;
    assign bus.SEG_CNT   = seg_cnt;
    assign bus.OVF       = ovf;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_gps_route_acc.sv
// Directed bench for gps_route_acc (ROUTE_LEN=4, FIFO_DEPTH=4) with an expected-result queue.
// Expected MAX_SEG follows GPS_ROUTE_MAX_EN so the bench serves both builds.
module tb_gps_route_acc;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wait;

    // {TOTAL[47:0], SEG_CNT[7:0], MAX_SEG[39:0]}
    logic [95:0] exp_q[$];

    gps_route_acc_if bus ();

    gps_route_acc #(
        .ROUTE_LEN (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [39:0] emax(input logic [39:0] m);
`ifdef GPS_ROUTE_MAX_EN
        return m;
`else
        return 40'd0 & m;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [39:0] d);
        bus.D_VALID = 1'b1;
        bus.D_IN    = d;
        @(negedge clk);
        bus.D_VALID = 1'b0;
        bus.D_IN    = '0;
    endtask

    task automatic push_exp(input logic [47:0] t, input logic [7:0] c, input logic [39:0] m);
        exp_q.push_back({t, c, emax(m)});
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!bus.OUT_VALID && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 64'(bus.OUT_VALID), 64'd1);
    endtask

    task automatic check_result(input string tag);
        logic [95:0] e;
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_total"},   64'(bus.TOTAL),   64'(e[95:48]));
            check({tag, "_seg_cnt"}, 64'(bus.SEG_CNT), 64'(e[47:40]));
            check({tag, "_max_seg"}, 64'(bus.MAX_SEG), 64'(e[39:0]));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 64'(bus.OUT_VALID), 64'd0);
        check({tag, "_total0"},    64'(bus.TOTAL),     64'd0);
        check({tag, "_seg_cnt0"},  64'(bus.SEG_CNT),   64'd0);
        check({tag, "_max_seg0"},  64'(bus.MAX_SEG),   64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.D_VALID   = 1'b0;
        bus.D_IN      = '0;
        bus.OUT_READY = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        check_idle("rst");
        check("rst_ovf", 64'(bus.OVF), 64'd0);
        check("rst_state", 64'(bus.fsm_state), 64'd0);

        // Spaced pulses, consumer always ready
        bus.OUT_READY = 1'b1;
        push_exp(48'd1000, 8'd4, 40'd400);
        pulse(40'd100); tick(2);
        pulse(40'd200); tick(2);
        pulse(40'd300); tick(2);
        pulse(40'd400);
        wait_valid(10, n_wait);
        check("t1_latency", 64'(n_wait), 64'd1);
        check("t1_state_hold", 64'(bus.fsm_state), 64'd1);
        check_result("t1");
        check("t1_ovf", 64'(bus.OVF), 64'd0);
        tick(1);
        check_idle("t1_after");

        // Back-to-back pulses including a zero segment
        push_exp(48'd14, 8'd4, 40'd7);
        pulse(40'd5);
        pulse(40'd0);
        pulse(40'd7);
        pulse(40'd2);
        wait_valid(10, n_wait);
        check("t2_latency", 64'(n_wait), 64'd1);
        check_result("t2");
        tick(1);
        check_idle("t2_after");

        // Consumer stalls: HOLD keeps the result, FIFO fills, fifth pulse dropped
        bus.OUT_READY = 1'b0;
        push_exp(48'd10, 8'd4, 40'd4);
        pulse(40'd1);
        pulse(40'd2);
        pulse(40'd3);
        pulse(40'd4);
        wait_valid(10, n_wait);
        check_result("t3a");
        for (int i = 0; i < 5; i++) begin
            pulse(40'd10);
        end
        check("t3_ovf", 64'(bus.OVF), 64'd1);
        check("t3_hold_total", 64'(bus.TOTAL), 64'd10);
        check("t3_hold_cnt", 64'(bus.SEG_CNT), 64'd4);
        tick(14);
        check("t3_hold_valid", 64'(bus.OUT_VALID), 64'd1);
        check("t3_hold_max", 64'(bus.MAX_SEG), 64'(emax(40'd4)));
        push_exp(48'd40, 8'd4, 40'd10);
        bus.OUT_READY = 1'b1;
        tick(1);
        check("t3_released", 64'(bus.OUT_VALID), 64'd0);
        wait_valid(20, n_wait);
        check("t3_resume_latency", 64'(n_wait), 64'd4);
        check_result("t3b");
        check("t3_ovf_sticky", 64'(bus.OVF), 64'd1);
        tick(1);

        // Reset mid-route discards partial work and clears OVF
        pulse(40'd5);
        pulse(40'd6);
        tick(2);
        check("t4_run_cnt", 64'(bus.SEG_CNT), 64'd2);
        check("t4_run_total", 64'(bus.TOTAL), 64'd11);
        reset = 1'b1;
        #1;
        check_idle("t4_in_reset");
        check("t4_ovf_clr", 64'(bus.OVF), 64'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check_idle("t4_post_reset");
        push_exp(48'd4, 8'd4, 40'd1);
        for (int i = 0; i < 4; i++) begin
            pulse(40'd1);
        end
        wait_valid(10, n_wait);
        check("t4_latency", 64'(n_wait), 64'd1);
        check_result("t4");
        tick(1);

        // Route whose maximum is not the last segment
        push_exp(48'd21, 8'd4, 40'd9);
        pulse(40'd9);
        pulse(40'd3);
        pulse(40'd8);
        pulse(40'd1);
        wait_valid(10, n_wait);
        check_result("t5");
        tick(1);
        check_idle("t5_after");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gps_route_acc.md
GPS_ROUTE_ACC -- requirements
Module: gps_route_acc

Interface
REQ-001 SHALL have parameter ROUTE_LEN, default 8: segments per route, legal range 1..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: input buffer entries, power of two, 2..16.
REQ-003 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port D_VALID  in  1  one-cycle pulse per segment distance (driven by distance-stage Valid).
REQ-006 SHALL have port D_IN  in  40  segment distance, same fixed-point format as distance-stage D; sampled when D_VALID=1.
REQ-007 SHALL have port OUT_READY  in  1  consumer accepts route result.
REQ-008 SHALL have port OUT_VALID  out  1  route result available.
REQ-009 SHALL have port TOTAL  out  48  sum of the route's segment distances.
REQ-010 SHALL have port SEG_CNT  out  8  segments summed into TOTAL.
REQ-011 SHALL have port MAX_SEG  out  40  largest segment of the route (see Configuration).
REQ-012 SHALL have port OVF  out  1  sticky flag: a segment was dropped.

Function
REQ-013 SHALL buffer samples in a FIFO of FIFO_DEPTH x 40 bits; write on D_VALID when the FIFO is not full at the start of the cycle.
REQ-014 SHALL drop the sample and set OVF when D_VALID=1 and the FIFO is full at cycle start, even if a pop occurs the same cycle; OVF holds until reset.
REQ-015 SHALL implement two states: ACCUM (reset state) and HOLD.
REQ-016 In ACCUM, SHALL pop one FIFO entry per cycle when non-empty: TOTAL += entry, SEG_CNT += 1, MAX_SEG = max(MAX_SEG, entry).
REQ-017 SHALL go to HOLD and assert OUT_VALID (registered) on the cycle after the pop that makes SEG_CNT equal ROUTE_LEN.
REQ-018 In HOLD, SHALL not pop; FIFO writes continue; TOTAL, SEG_CNT, MAX_SEG stay stable.
REQ-019 When OUT_VALID=1 and OUT_READY=1, SHALL clear TOTAL, SEG_CNT, MAX_SEG, deassert OUT_VALID and enter ACCUM next cycle; pops resume that cycle.
REQ-020 SHALL ignore OUT_READY while OUT_VALID=0.
REQ-021 Latency: D_VALID at cycle t into an empty FIFO in ACCUM -> popped at t+1, accumulators updated at t+2; if final segment, OUT_VALID=1 at t+2.
REQ-022 SHALL count zero-valued segments as segments.
REQ-023 TOTAL width SHALL need no saturation (255 x (2^40-1) < 2^48); addition is plain unsigned.
REQ-024 Outputs SHALL show running accumulator values in ACCUM; meaningful only while OUT_VALID=1.

Reset
REQ-025 On reset: state=ACCUM, FIFO empty, OUT_VALID=0, TOTAL=0, SEG_CNT=0, MAX_SEG=0, OVF=0.
REQ-026 Reset mid-route or mid-HOLD SHALL discard buffered and accumulated data with no output.

Configuration
REQ-027 Macro GPS_ROUTE_MAX_EN defined: MAX_SEG tracking per REQ-016.
REQ-028 Macro undefined: no max comparator or register; MAX_SEG tied to 0; all else unchanged.

Verification (ROUTE_LEN=4, FIFO_DEPTH=4, macro defined unless noted)
REQ-029 Pulses D_IN=100,200,300,400, 3 cycles apart, OUT_READY=1 -> OUT_VALID 1 cycle, TOTAL=1000, SEG_CNT=4, MAX_SEG=400, OVF=0.
REQ-030 Back-to-back pulses 5,0,7,2 (consecutive cycles) -> OUT_VALID 2 cycles after last pulse, TOTAL=14, SEG_CNT=4, MAX_SEG=7.
REQ-031 First route completes, OUT_READY=0 for 20 cycles, 5 further pulses of 10 -> 5th dropped, OVF=1; after OUT_READY=1 next route TOTAL=40, SEG_CNT=4.
REQ-032 Reset after 2 of 4 segments -> all outputs 0; then 4 pulses of 1 -> TOTAL=4, SEG_CNT=4.
REQ-033 Macro undefined, pulses 9,3,8,1 -> TOTAL=21, MAX_SEG=0.
